// File: rtl/prenorm_align_pipe_if.sv
// Operand/result bundle for the FMA pre-normalisation aligner.
// The environment side uses modport master, the aligner uses modport slave.
interface prenorm_align_pipe_if #(
  parameter int unsigned PARM_EXP  = 8,
  parameter int unsigned PARM_MANT = 23
);
  localparam int unsigned W_E   = PARM_EXP + 2;
  localparam int unsigned W_OUT = 3 * PARM_MANT + 6;

  // Upstream operand handshake
  logic                 valid_i;
  logic                 ready_o;
  logic                 A_sign_i;
  logic                 B_sign_i;
  logic                 C_sign_i;
  logic [PARM_EXP-1:0]  A_Exp_i;
  logic [PARM_EXP-1:0]  B_Exp_i;
  logic [PARM_EXP-1:0]  C_Exp_i;
  logic [PARM_MANT:0]   A_Mant_i;

  // Downstream result handshake
  logic                 valid_o;
  logic                 ready_i;
  logic                 Sign_aligned_o;
  logic [W_E-1:0]       Exp_aligned_o;
  logic [W_OUT-1:0]     A_Mant_aligned_o;
  logic                 Sticky_o;
  logic                 Sub_o;
  logic                 Halt_o;
  logic                 A_dom_o;

  modport master (
    output valid_i, A_sign_i, B_sign_i, C_sign_i,
           A_Exp_i, B_Exp_i, C_Exp_i, A_Mant_i, ready_i,
    input  ready_o, valid_o, Sign_aligned_o, Exp_aligned_o,
           A_Mant_aligned_o, Sticky_o, Sub_o, Halt_o, A_dom_o
  );

  modport slave (
    input  valid_i, A_sign_i, B_sign_i, C_sign_i,
           A_Exp_i, B_Exp_i, C_Exp_i, A_Mant_i, ready_i,
    output ready_o, valid_o, Sign_aligned_o, Exp_aligned_o,
           A_Mant_aligned_o, Sticky_o, Sub_o, Halt_o, A_dom_o
  );

endinterface

// File: rtl/prenorm_align_pipe.sv
// Two-stage addend aligner for A + B*C with a global stall.
// Define PRENORM_HALT_CNT_EN to add the saturating halt_cnt_o counter.
module prenorm_align_pipe #(
  parameter int unsigned PARM_EXP  = 8,
  parameter int unsigned PARM_MANT = 23,
  parameter int unsigned PARM_BIAS = 127
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  prenorm_align_pipe_if.slave   bus
`ifdef PRENORM_HALT_CNT_EN
  ,
  output logic [15:0]           halt_cnt_o
`endif
);

  localparam int unsigned W_E   = PARM_EXP + 2;
  localparam int unsigned W_AL  = 3 * PARM_MANT + 5;
  localparam int unsigned W_OUT = W_AL + 1;
  localparam int unsigned D_PT  = PARM_MANT + 4;
  localparam int unsigned W_M   = PARM_MANT + 1;
  localparam int unsigned W_V   = W_AL + W_M;
  localparam int unsigned SH_A  = 2 * PARM_MANT + 4;

  // Stage 1: registered operands plus exponent-difference decode
  logic                valid1_q,   valid1_d;
  logic                a_sign1_q,  a_sign1_d;
  logic                sign_bc1_q, sign_bc1_d;
  logic                sub1_q,     sub1_d;
  logic [PARM_EXP-1:0] a_exp1_q,   a_exp1_d;
  logic [W_E-1:0]      exp_ref1_q, exp_ref1_d;
  logic [W_M-1:0]      a_mant1_q,  a_mant1_d;
  logic [W_E-1:0]      d1_q,       d1_d;
  logic                a_dom1_q,   a_dom1_d;
  logic                halt1_q,    halt1_d;

  // Stage 2: registered outputs
  logic                valid2_q,   valid2_d;
  logic                sign2_q,    sign2_d;
  logic [W_E-1:0]      exp2_q,     exp2_d;
  logic [W_OUT-1:0]    mant2_q,    mant2_d;
  logic                sticky2_q,  sticky2_d;
  logic                sub2_q,     sub2_d;
  logic                halt2_q,    halt2_d;
  logic                adom2_q,    adom2_d;

  logic                adv_c;
  logic [W_E-1:0]      exp_ref_c;
  logic [W_E-1:0]      d_c;
  logic                halt_c;
  logic [W_V-1:0]      v_c;

  assign adv_c       = ~valid2_q | bus.ready_i;
  assign bus.ready_o = adv_c;

  // Product exponent referenced to the alignment point; wraps modulo 2^W_E
  assign exp_ref_c = W_E'(bus.B_Exp_i) + W_E'(bus.C_Exp_i)
                   - W_E'(PARM_BIAS) + W_E'(D_PT);
  assign d_c       = exp_ref_c - W_E'(bus.A_Exp_i);
  assign halt_c    = $signed(d_c) > $signed(W_E'(W_AL));

  // Only consumed when 0 <= d <= W_AL, so the unsigned shift amount is exact
  assign v_c = {a_mant1_q, {W_AL{1'b0}}} >> d1_q;

  always_comb begin
    valid1_d   = valid1_q;
    a_sign1_d  = a_sign1_q;
    sign_bc1_d = sign_bc1_q;
    sub1_d     = sub1_q;
    a_exp1_d   = a_exp1_q;
    exp_ref1_d = exp_ref1_q;
    a_mant1_d  = a_mant1_q;
    d1_d       = d1_q;
    a_dom1_d   = a_dom1_q;
    halt1_d    = halt1_q;
    valid2_d   = valid2_q;
    sign2_d    = sign2_q;
    exp2_d     = exp2_q;
    mant2_d    = mant2_q;
    sticky2_d  = sticky2_q;
    sub2_d     = sub2_q;
    halt2_d    = halt2_q;
    adom2_d    = adom2_q;

    if (adv_c) begin
      valid1_d   = bus.valid_i;
      a_sign1_d  = bus.A_sign_i;
      sign_bc1_d = bus.B_sign_i ^ bus.C_sign_i;
      sub1_d     = bus.A_sign_i ^ bus.B_sign_i ^ bus.C_sign_i;
      a_exp1_d   = bus.A_Exp_i;
      exp_ref1_d = exp_ref_c;
      a_mant1_d  = bus.A_Mant_i;
      d1_d       = d_c;
      a_dom1_d   = d_c[W_E-1];
      halt1_d    = halt_c;

      valid2_d   = valid1_q;
      sub2_d     = sub1_q;
      adom2_d    = a_dom1_q;
      halt2_d    = halt1_q & ~a_dom1_q;

      if (a_dom1_q) begin
        sign2_d   = a_sign1_q;
        exp2_d    = W_E'(a_exp1_q);
        mant2_d   = W_OUT'(a_mant1_q) << SH_A;
        sticky2_d = 1'b0;
      end else if (halt1_q) begin
        sign2_d   = sign_bc1_q;
        exp2_d    = exp_ref1_q;
        mant2_d   = '0;
        sticky2_d = |a_mant1_q;
      end else begin
        // Effective subtract: one's complement of the aligned addend, flag in MSB
        sign2_d   = sign_bc1_q;
        exp2_d    = exp_ref1_q;
        mant2_d   = {sub1_q, {W_AL{sub1_q}} ^ v_c[W_V-1 -: W_AL]};
        sticky2_d = |v_c[W_M-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid1_q   <= 1'b0;
      a_sign1_q  <= 1'b0;
      sign_bc1_q <= 1'b0;
      sub1_q     <= 1'b0;
      a_exp1_q   <= '0;
      exp_ref1_q <= '0;
      a_mant1_q  <= '0;
      d1_q       <= '0;
      a_dom1_q   <= 1'b0;
      halt1_q    <= 1'b0;
      valid2_q   <= 1'b0;
      sign2_q    <= 1'b0;
      exp2_q     <= '0;
      mant2_q    <= '0;
      sticky2_q  <= 1'b0;
      sub2_q     <= 1'b0;
      halt2_q    <= 1'b0;
      adom2_q    <= 1'b0;
    end else begin
      valid1_q   <= valid1_d;
      a_sign1_q  <= a_sign1_d;
      sign_bc1_q <= sign_bc1_d;
      sub1_q     <= sub1_d;
      a_exp1_q   <= a_exp1_d;
      exp_ref1_q <= exp_ref1_d;
      a_mant1_q  <= a_mant1_d;
      d1_q       <= d1_d;
      a_dom1_q   <= a_dom1_d;
      halt1_q    <= halt1_d;
      valid2_q   <= valid2_d;
      sign2_q    <= sign2_d;
      exp2_q     <= exp2_d;
      mant2_q    <= mant2_d;
      sticky2_q  <= sticky2_d;
      sub2_q     <= sub2_d;
      halt2_q    <= halt2_d;
      adom2_q    <= adom2_d;
    end
  end

  assign bus.valid_o          = valid2_q;
  assign bus.Sign_aligned_o   = sign2_q;
  assign bus.Exp_aligned_o    = exp2_q;
  assign bus.A_Mant_aligned_o = mant2_q;
  assign bus.Sticky_o         = sticky2_q;
  assign bus.Sub_o            = sub2_q;
  assign bus.Halt_o           = halt2_q;
  assign bus.A_dom_o          = adom2_q;

`ifdef PRENORM_HALT_CNT_EN
  logic [15:0] halt_cnt_q, halt_cnt_d;

  // Saturating count of halted results actually handed downstream
  always_comb begin
    halt_cnt_d = halt_cnt_q;
    if (valid2_q && bus.ready_i && halt2_q && (halt_cnt_q != 16'hFFFF)) begin
      halt_cnt_d = halt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      halt_cnt_q <= '0;
    end else begin
      halt_cnt_q <= halt_cnt_d;
    end
  end

  assign halt_cnt_o = halt_cnt_q;
`endif

endmodule

// File: doc/prenorm_align_pipe.md
PRENORM_ALIGN_PIPE -- requirements
Module: prenorm_align_pipe

Interface
REQ-001 SHALL have parameter PARM_EXP, default 8, exponent width.
REQ-002 SHALL have parameter PARM_MANT, default 23, stored fraction width; mantissa input is PARM_MANT+1 bits with the hidden bit included.
REQ-003 SHALL have parameter PARM_BIAS, default 127, exponent bias.
REQ-004 SHALL define derived widths: W_AL = 3*PARM_MANT+5 (74 at default), W_OUT = W_AL+1, D_PT = PARM_MANT+4 (27 at default).
REQ-005 clk_i  in  1  sole clock, rising edge.
REQ-006 rst_i  in  1  synchronous, active-high reset.
REQ-007 valid_i  in  1  input operand set valid.
REQ-008 ready_o  out  1  block accepts input this cycle.
REQ-009 A_sign_i, B_sign_i, C_sign_i  in  1 each  operand signs; result = A + B*C.
REQ-010 A_Exp_i, B_Exp_i, C_Exp_i  in  PARM_EXP each  biased exponents.
REQ-011 A_Mant_i  in  PARM_MANT+1  addend mantissa.
REQ-012 valid_o  out  1  output set valid.
REQ-013 ready_i  in  1  downstream accepts output.
REQ-014 Sign_aligned_o  out  1  sign of the dominant operand.
REQ-015 Exp_aligned_o  out  PARM_EXP+2  reference exponent.
REQ-016 A_Mant_aligned_o  out  W_OUT  aligned addend; MSB is the subtract flag.
REQ-017 Sticky_o  out  1  OR of all addend bits shifted out.
REQ-018 Sub_o, Halt_o, A_dom_o  out  1 each  effective-subtract, shift-saturated, and addend-dominant flags.

Function
REQ-019 Stage 1 SHALL register the operands on accept (valid_i & ready_o) and compute the signed (PARM_EXP+2)-bit d = B_Exp+C_Exp-PARM_BIAS-A_Exp+D_PT, sub = A^B^C sign, A_dom = (d<0), and halt = (d>W_AL).
REQ-020 Stage 2 SHALL register every output, giving exactly 2 cycles of latency from accept to valid_o with throughput 1 per cycle.
REQ-021 The pipeline SHALL use a global stall: adv = ~valid_o | ready_i, ready_o = adv, and both stages hold their contents while adv=0.
REQ-022 While valid_o=1 and ready_i=0, all outputs SHALL remain bit-stable.
REQ-023 When A_dom=1: Sign=A_sign, Exp=A_Exp zero-extended, Mant = A_Mant << (2*PARM_MANT+4) in W_OUT bits, Sticky=0, Halt=0.
REQ-024 When A_dom=0 and halt=1: Sign=B^C sign, Exp=B_Exp+C_Exp-PARM_BIAS+D_PT, Mant=0, Sticky=|A_Mant.
REQ-025 Otherwise, with V = {A_Mant, W_AL zeros} >> d: Mant = {sub, {W_AL{sub}} ^ V[top W_AL bits]}, Sticky = |V[low PARM_MANT+1 bits], and Sign and Exp as in REQ-024.
REQ-026 Exponent arithmetic SHALL be performed in PARM_EXP+2 bits with no saturation; results wrap modulo 2^(PARM_EXP+2).
REQ-027 Bubbles (valid_i=0 on an advance) SHALL propagate as valid=0; a stage's data is don't-care while its valid is 0.

Reset
REQ-028 When rst_i=1 at a rising edge, both stage valid bits SHALL clear and every registered output SHALL become 0, overriding any simultaneous accept or stall.
REQ-029 Data in flight at reset SHALL be discarded; ready_o SHALL be 1 in the first cycle after reset.

Configuration
REQ-030 With PRENORM_HALT_CNT_EN defined, the block SHALL add output halt_cnt_o[15:0], which counts Halt_o outputs transferred (valid_o & ready_i & Halt_o), saturates at 0xFFFF, and is reset to 0.
REQ-031 Without PRENORM_HALT_CNT_EN, the port and the counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-032 A=+1.0 (exp 127, mant 0x800000), B=C=+1.0 -> after 2 cycles: Mant=2^46, Exp=154, Sign=0, Sub=0, Sticky=0, A_dom=0.
REQ-033 Same operands with A_sign=1 -> Mant = {1'b1, ~(74'b1<<46)}, Sub=1, Sign=0.
REQ-034 A_Exp=200, B_Exp=C_Exp=127 -> A_dom=1, Mant=2^73, Exp=200, Sign=A_sign.
REQ-035 A_Exp=1, B_Exp=C_Exp=200, A_Mant=0x800000 -> Halt=1, Mant=0, Sticky=1, Exp=300; halt_cnt_o increments to 1 when the counter is enabled.
REQ-036 Stream of 4 back-to-back inputs with ready_i=0 for 3 cycles after the first valid_o -> ready_o=0 during the stall, outputs stable, all 4 results delivered in order with none lost or duplicated.
REQ-037 rst_i asserted for 1 cycle with 2 items in flight -> valid_o=0 and all outputs 0 on the next cycle, and no stale item is ever emitted.
